andla_cdma_rf: RTL and testbench
================================

// Module: andla_cdma_rf
// PURPOSE
//  Register-file slice that programs the CDMA engine: the producer side of the rf_cdma_* interface.
//  - Decodes simple register-bus writes and reads.
//  - Holds the transfer descriptor and issues the one-cycle rf_cdma_sfence kick.
//  - Tracks busy until the engine reports done or an exception; sticky status drives an interrupt line.
// PARAMETERS
//  CDMA_DIRECTION_BITWIDTH       1   transfer direction (0 exram->local, 1 local->exram)
//  CDMA_EXRAM_ADDR_LSB_BITWIDTH  32  low address word width
//  CDMA_EXRAM_ADDR_MSB_BITWIDTH  8   high address word width
//  CDMA_EXRAM_ADDR_BITWIDTH      40  MSB+LSB concatenated
//  CDMA_EXRAM_C_BITWIDTH         16  channel count
//  CDMA_EXRAM_W_BITWIDTH         16  width count
//  CDMA_EXRAM_STRIDE_W_BITWIDTH  32  row stride in bytes
// PORTS
//  clk                     in   1    clock
//  rst_n                   in   1    async reset, active low
//  rf_wr_en                in   1    register write strobe, single cycle
//  rf_rd_en                in   1    register read strobe, single cycle
//  rf_addr                 in   8    byte offset
//  rf_wdata                in   32   write data
//  rf_rdata                out  32   read data
//  rf_rdata_vld            out  1    read data valid
//  rf_cdma_sfence          out  1    one-cycle kick to CDMA
//  rf_cdma_direction       out  DIR  descriptor field
//  rf_cdma_exram_addr      out  ADDR {MSB,LSB}
//  rf_cdma_exram_c         out  C    descriptor field
//  rf_cdma_exram_w         out  W    descriptor field
//  rf_cdma_exram_stride_w  out  SW   descriptor field
//  cdma_done               in   1    one-cycle completion pulse from CDMA
//  rf_cdma_except_trigger  in   1    one-cycle exception pulse from CDMA
//  cdma_irq                out  1    level interrupt = done_stk | except_stk
// BEHAVIOUR
//  - Reset: all outputs and registers 0; FSM in IDLE.
//  - Register map:
//      0x00 SFENCE: write bit0=1 kicks; read returns {31'b0,busy}
//      0x04 DIR
//      0x08 ADDR_LSB
//      0x0C ADDR_MSB
//      0x10 C
//      0x14 W
//      0x18 STRIDE_W
//      0x1C STATUS: bit0 except_stk, bit1 busy, bit2 wr_err_stk, bit3 done_stk; bits 0, 2, 3 are W1C
//    Unmapped reads return 0; unmapped writes are ignored.
//    Fields are right-aligned in the 32-bit word; upper bits read as 0.
//  - Reads: rf_rdata/rf_rdata_vld are registered, one cycle after rf_rd_en.
//    rf_rdata holds its value when vld=0. Read and write in the same cycle are both honoured.
//  - FSM, IDLE -> KICK -> BUSY -> IDLE:
//      IDLE: SFENCE write with bit0=1 -> KICK; bit0=0 is a no-op.
//      KICK: rf_cdma_sfence=1 for exactly one cycle -> BUSY.
//      BUSY: cdma_done -> IDLE and set done_stk; rf_cdma_except_trigger -> IDLE and set except_stk.
//            Both in the same cycle: both stickies set, single transition to IDLE.
//      SFENCE write while not IDLE: ignored, sets wr_err_stk.
//  - Done or except pulse arriving while IDLE/KICK: sticky still set, FSM unchanged.
//  - Sticky set and W1C clear in the same cycle: set wins.
//  - Mid-operation reset returns to IDLE with stickies cleared; no sfence is emitted during or after reset.
// CONFIGURATION
//  - CDMA_RF_SHADOW_EN defined:
//    - Descriptor writes land in shadow registers at any time.
//    - Shadow copies to the live outputs on the KICK cycle; rf_cdma_* outputs are stable through BUSY.
//    - Reads of 0x04-0x18 return shadow values.
//  - CDMA_RF_SHADOW_EN undefined:
//    - The live registers drive the outputs directly.
//    - Descriptor writes while busy are dropped and set wr_err_stk.
//    - Reads return live values.
// STRUCTURE
//  - andla.vh: bitwidth defines, register offsets (CDMA_RF_*_OFS), FSM state encodings.
//  - Sub-module andla_cdma_rf_ctrl: FSM plus sticky status and irq.
//  - Top level holds the address decode, descriptor or shadow registers and the read mux.
// TESTING
//  1. Reset value check: after reset, read every register.
//     -> all return 0; cdma_irq=0; rf_cdma_sfence never asserted.
//  2. Program and kick: write ADDR_LSB=0x1000_0000, ADDR_MSB=0x12, C=3, W=64, STRIDE_W=256, then SFENCE=1.
//     -> exram_addr=0x12_1000_0000; sfence high for exactly 1 cycle, 1 cycle after the write.
//     -> STATUS.busy=1; cdma_done pulse -> busy=0, done_stk=1, irq=1.
//  3. Exception: kick, then pulse except_trigger and cdma_done in the same cycle.
//     -> STATUS reads 0x9, busy clears; W1C 0x9 -> STATUS=0 and irq=0.
//  4. Busy protection: while BUSY, write SFENCE=1 and C=7.
//     -> no second sfence; wr_err_stk=1.
//     -> SHADOW_EN: output C stays 3 and reads 7, next kick drives 7.
//     -> no SHADOW_EN: C stays 3 on both read and output.
//  5. Set-vs-clear race: W1C bit0 in the same cycle as an except pulse.
//     -> except_stk remains 1.
//  6. Reset mid-BUSY: assert rst_n=0 during BUSY.
//     -> FSM IDLE, STATUS=0, descriptor=0, no sfence after release.

Source files
------------

// File: rtl/andla_cdma_rf_pkg.sv
// Shared register offsets, status bit positions and FSM states
// for the CDMA register-file slice.
package andla_cdma_rf_pkg;

    localparam logic [7:0] CDMA_RF_SFENCE_OFS   = 8'h00;
    localparam logic [7:0] CDMA_RF_DIR_OFS      = 8'h04;
    localparam logic [7:0] CDMA_RF_ADDR_LSB_OFS = 8'h08;
    localparam logic [7:0] CDMA_RF_ADDR_MSB_OFS = 8'h0C;
    localparam logic [7:0] CDMA_RF_C_OFS        = 8'h10;
    localparam logic [7:0] CDMA_RF_W_OFS        = 8'h14;
    localparam logic [7:0] CDMA_RF_STRIDE_W_OFS = 8'h18;
    localparam logic [7:0] CDMA_RF_STATUS_OFS   = 8'h1C;

    localparam int CDMA_STS_EXCEPT = 0;
    localparam int CDMA_STS_BUSY   = 1;
    localparam int CDMA_STS_WR_ERR = 2;
    localparam int CDMA_STS_DONE   = 3;

    typedef enum logic [1:0] {
        CDMA_IDLE = 2'd0,
        CDMA_KICK = 2'd1,
        CDMA_BUSY = 2'd2
    } cdma_state_e;

endpackage

// File: rtl/andla_cdma_rf_if.sv
// Simple register bus: single-cycle write/read strobes,
// read data returned one cycle later with a valid flag.
interface andla_cdma_rf_if;

    logic        rf_wr_en;
    logic        rf_rd_en;
    logic [7:0]  rf_addr;
    logic [31:0] rf_wdata;
    logic [31:0] rf_rdata;
    logic        rf_rdata_vld;

    modport master (
        output rf_wr_en,
        output rf_rd_en,
        output rf_addr,
        output rf_wdata,
        input  rf_rdata,
        input  rf_rdata_vld
    );

    modport slave (
        input  rf_wr_en,
        input  rf_rd_en,
        input  rf_addr,
        input  rf_wdata,
        output rf_rdata,
        output rf_rdata_vld
    );

endinterface

// File: rtl/andla_cdma_rf_ctrl.sv
// Kick/busy FSM for the CDMA engine plus sticky status bits
// and the level interrupt derived from them.
module andla_cdma_rf_ctrl
    import andla_cdma_rf_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       sfence_wr,
    input  logic       sfence_bit,
    input  logic       desc_err,
    input  logic       clr_except,
    input  logic       clr_wr_err,
    input  logic       clr_done,
    input  logic       cdma_done,
    input  logic       except_trigger,
    output logic       kick_go,
    output logic       rf_cdma_sfence,
    output logic       busy,
    output logic [3:0] status,
    output logic       cdma_irq
);

    cdma_state_e state;
    logic        except_stk;
    logic        wr_err_stk;
    logic        done_stk;
    logic        wr_err_set;

    assign busy       = (state != CDMA_IDLE);
    assign kick_go    = sfence_wr && sfence_bit && !busy;
    assign wr_err_set = (sfence_wr && busy) || desc_err;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= CDMA_IDLE;
            rf_cdma_sfence <= 1'b0;
            except_stk     <= 1'b0;
            wr_err_stk     <= 1'b0;
            done_stk       <= 1'b0;
        end else begin
            rf_cdma_sfence <= 1'b0;
            unique case (state)
                CDMA_IDLE: begin
                    if (kick_go) begin
                        state          <= CDMA_KICK;
                        rf_cdma_sfence <= 1'b1;
                    end
                end
                CDMA_KICK: state <= CDMA_BUSY;
                CDMA_BUSY: begin
                    if (cdma_done || except_trigger)
                        state <= CDMA_IDLE;
                end
                default: state <= CDMA_IDLE;
            endcase
            // a set in the same cycle as a W1C clear wins
            except_stk <= except_trigger
                        || (except_stk && !clr_except);
            wr_err_stk <= wr_err_set
                        || (wr_err_stk && !clr_wr_err);
            done_stk   <= cdma_done
                        || (done_stk && !clr_done);
        end
    end

    always_comb begin
        status                  = '0;
        status[CDMA_STS_EXCEPT] = except_stk;
        status[CDMA_STS_BUSY]   = busy;
        status[CDMA_STS_WR_ERR] = wr_err_stk;
        status[CDMA_STS_DONE]   = done_stk;
    end

    assign cdma_irq = done_stk || except_stk;

endmodule

// File: rtl/andla_cdma_rf.sv
// CDMA register-file slice: decode, descriptor regs, read mux.
// Optional CDMA_RF_SHADOW_EN: descriptor shadows copied on kick.
module andla_cdma_rf
    import andla_cdma_rf_pkg::*;
#(
    parameter int CDMA_DIRECTION_BITWIDTH      = 1,
    parameter int CDMA_EXRAM_ADDR_LSB_BITWIDTH = 32,
    parameter int CDMA_EXRAM_ADDR_MSB_BITWIDTH = 8,
    parameter int CDMA_EXRAM_ADDR_BITWIDTH     = 40,
    parameter int CDMA_EXRAM_C_BITWIDTH        = 16,
    parameter int CDMA_EXRAM_W_BITWIDTH        = 16,
    parameter int CDMA_EXRAM_STRIDE_W_BITWIDTH = 32
) (
    input  logic clk,
    input  logic rst_n,
    andla_cdma_rf_if.slave rf,
    output logic rf_cdma_sfence,
    output logic [CDMA_DIRECTION_BITWIDTH-1:0]      rf_cdma_direction,
    output logic [CDMA_EXRAM_ADDR_BITWIDTH-1:0]     rf_cdma_exram_addr,
    output logic [CDMA_EXRAM_C_BITWIDTH-1:0]        rf_cdma_exram_c,
    output logic [CDMA_EXRAM_W_BITWIDTH-1:0]        rf_cdma_exram_w,
    output logic [CDMA_EXRAM_STRIDE_W_BITWIDTH-1:0] rf_cdma_exram_stride_w,
    input  logic cdma_done,
    input  logic rf_cdma_except_trigger,
    output logic cdma_irq
);

    localparam int DW = CDMA_DIRECTION_BITWIDTH;
    localparam int LW = CDMA_EXRAM_ADDR_LSB_BITWIDTH;
    localparam int MW = CDMA_EXRAM_ADDR_MSB_BITWIDTH;
    localparam int AW = CDMA_EXRAM_ADDR_BITWIDTH;
    localparam int CW = CDMA_EXRAM_C_BITWIDTH;
    localparam int WW = CDMA_EXRAM_W_BITWIDTH;
    localparam int SW = CDMA_EXRAM_STRIDE_W_BITWIDTH;

    logic          wr_sfence;
    logic          wr_dir;
    logic          wr_lsb;
    logic          wr_msb;
    logic          wr_c;
    logic          wr_w;
    logic          wr_sw;
    logic          wr_status;
    logic          desc_ok;
    logic          desc_err;
    logic          kick_go;
    logic          busy;
    logic [3:0]    status;
    logic [31:0]   rd_mux;

    logic [DW-1:0] dir_q;
    logic [LW-1:0] lsb_q;
    logic [MW-1:0] msb_q;
    logic [CW-1:0] c_q;
    logic [WW-1:0] w_q;
    logic [SW-1:0] sw_q;

    assign wr_sfence = rf.rf_wr_en && (rf.rf_addr == CDMA_RF_SFENCE_OFS);
    assign wr_dir    = rf.rf_wr_en && (rf.rf_addr == CDMA_RF_DIR_OFS);
    assign wr_lsb    = rf.rf_wr_en && (rf.rf_addr == CDMA_RF_ADDR_LSB_OFS);
    assign wr_msb    = rf.rf_wr_en && (rf.rf_addr == CDMA_RF_ADDR_MSB_OFS);
    assign wr_c      = rf.rf_wr_en && (rf.rf_addr == CDMA_RF_C_OFS);
    assign wr_w      = rf.rf_wr_en && (rf.rf_addr == CDMA_RF_W_OFS);
    assign wr_sw     = rf.rf_wr_en && (rf.rf_addr == CDMA_RF_STRIDE_W_OFS);
    assign wr_status = rf.rf_wr_en && (rf.rf_addr == CDMA_RF_STATUS_OFS);

`ifdef CDMA_RF_SHADOW_EN
    assign desc_ok  = 1'b1;
    assign desc_err = 1'b0;
`else
    logic desc_wr;
    assign desc_wr  = wr_dir || wr_lsb || wr_msb
                   || wr_c || wr_w || wr_sw;
    assign desc_ok  = !busy;
    assign desc_err = desc_wr && busy;
`endif

    // host-visible descriptor copy (shadow when enabled, else live)
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dir_q <= '0;
            lsb_q <= '0;
            msb_q <= '0;
            c_q   <= '0;
            w_q   <= '0;
            sw_q  <= '0;
        end else if (desc_ok) begin
            if (wr_dir) dir_q <= rf.rf_wdata[DW-1:0];
            if (wr_lsb) lsb_q <= rf.rf_wdata[LW-1:0];
            if (wr_msb) msb_q <= rf.rf_wdata[MW-1:0];
            if (wr_c)   c_q   <= rf.rf_wdata[CW-1:0];
            if (wr_w)   w_q   <= rf.rf_wdata[WW-1:0];
            if (wr_sw)  sw_q  <= rf.rf_wdata[SW-1:0];
        end
    end

`ifdef CDMA_RF_SHADOW_EN
    logic [DW-1:0] live_dir;
    logic [LW-1:0] live_lsb;
    logic [MW-1:0] live_msb;
    logic [CW-1:0] live_c;
    logic [WW-1:0] live_w;
    logic [SW-1:0] live_sw;

    // copy lands with the sfence pulse so the engine sees it at once
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            live_dir <= '0;
            live_lsb <= '0;
            live_msb <= '0;
            live_c   <= '0;
            live_w   <= '0;
            live_sw  <= '0;
        end else if (kick_go) begin
            live_dir <= dir_q;
            live_lsb <= lsb_q;
            live_msb <= msb_q;
            live_c   <= c_q;
            live_w   <= w_q;
            live_sw  <= sw_q;
        end
    end

    assign rf_cdma_direction      = live_dir;
    assign rf_cdma_exram_addr     = AW'({live_msb, live_lsb});
    assign rf_cdma_exram_c        = live_c;
    assign rf_cdma_exram_w        = live_w;
    assign rf_cdma_exram_stride_w = live_sw;
`else
    assign rf_cdma_direction      = dir_q;
    assign rf_cdma_exram_addr     = AW'({msb_q, lsb_q});
    assign rf_cdma_exram_c        = c_q;
    assign rf_cdma_exram_w        = w_q;
    assign rf_cdma_exram_stride_w = sw_q;
`endif

    andla_cdma_rf_ctrl u_ctrl (
        .clk            (clk),
        .rst_n          (rst_n),
        .sfence_wr      (wr_sfence),
        .sfence_bit     (rf.rf_wdata[0]),
        .desc_err       (desc_err),
        .clr_except     (wr_status && rf.rf_wdata[CDMA_STS_EXCEPT]),
        .clr_wr_err     (wr_status && rf.rf_wdata[CDMA_STS_WR_ERR]),
        .clr_done       (wr_status && rf.rf_wdata[CDMA_STS_DONE]),
        .cdma_done      (cdma_done),
        .except_trigger (rf_cdma_except_trigger),
        .kick_go        (kick_go),
        .rf_cdma_sfence (rf_cdma_sfence),
        .busy           (busy),
        .status         (status),
        .cdma_irq       (cdma_irq)
    );

    always_comb begin
        rd_mux = '0;
        unique case (rf.rf_addr)
            CDMA_RF_SFENCE_OFS:   rd_mux = {31'b0, busy};
            CDMA_RF_DIR_OFS:      rd_mux = 32'(dir_q);
            CDMA_RF_ADDR_LSB_OFS: rd_mux = 32'(lsb_q);
            CDMA_RF_ADDR_MSB_OFS: rd_mux = 32'(msb_q);
            CDMA_RF_C_OFS:        rd_mux = 32'(c_q);
            CDMA_RF_W_OFS:        rd_mux = 32'(w_q);
            CDMA_RF_STRIDE_W_OFS: rd_mux = 32'(sw_q);
            CDMA_RF_STATUS_OFS:   rd_mux = {28'b0, status};
            default:              rd_mux = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rf.rf_rdata     <= '0;
            rf.rf_rdata_vld <= 1'b0;
        end else begin
            rf.rf_rdata_vld <= rf.rf_rd_en;
            if (rf.rf_rd_en)
                rf.rf_rdata <= rd_mux;
        end
    end

endmodule

// File: tb/tb_andla_cdma_rf.sv
// Randomized bench for andla_cdma_rf against a register-level model.
// Honors CDMA_RF_SHADOW_EN the same way as the RTL build.
module tb_andla_cdma_rf;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cdma_done = 1'b0;
    logic        except_trig = 1'b0;
    logic        sfence;
    logic [0:0]  dir;
    logic [39:0] xaddr;
    logic [15:0] xc;
    logic [15:0] xw;
    logic [31:0] xsw;
    logic        irq;

    andla_cdma_rf_if bus ();

    andla_cdma_rf dut (
        .clk                    (clk),
        .rst_n                  (rst_n),
        .rf                     (bus),
        .rf_cdma_sfence         (sfence),
        .rf_cdma_direction      (dir),
        .rf_cdma_exram_addr     (xaddr),
        .rf_cdma_exram_c        (xc),
        .rf_cdma_exram_w        (xw),
        .rf_cdma_exram_stride_w (xsw),
        .cdma_done              (cdma_done),
        .rf_cdma_except_trigger (except_trig),
        .cdma_irq               (irq)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // model state: descriptor words indexed by offset/4
    bit          m_active;
    bit          m_kick;
    bit          m_exc;
    bit          m_err;
    bit          m_done;
    logic [31:0] m_desc [7];
    logic [31:0] m_live [7];
    logic [31:0] m_rdata;
    bit          m_vld;
    bit          m_sf;

    task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] fmask(int i);
        case (i)
            1: return 32'h1;
            2: return 32'hFFFF_FFFF;
            3: return 32'hFF;
            4: return 32'hFFFF;
            5: return 32'hFFFF;
            6: return 32'hFFFF_FFFF;
            default: return 32'h0;
        endcase
    endfunction

    function automatic logic [31:0] model_read(logic [7:0] a);
        int idx;
        if (a[1:0] != 2'b00 || a > 8'h1C) return 32'h0;
        idx = int'(a >> 2);
        if (idx == 0) return {31'b0, m_active};
        if (idx == 7) return {28'b0, m_done, m_err, m_active, m_exc};
        return m_desc[idx];
    endfunction

    task automatic model_reset();
        m_active = 0; m_kick = 0;
        m_exc = 0; m_err = 0; m_done = 0;
        m_rdata = '0; m_vld = 0; m_sf = 0;
        for (int i = 0; i < 7; i++) begin
            m_desc[i] = '0;
            m_live[i] = '0;
        end
    endtask

    task automatic cmp_outputs(string tag);
        chk({tag, "_sfence"}, 64'(sfence), 64'(m_sf));
        chk({tag, "_irq"}, 64'(irq), 64'(m_done | m_exc));
        chk({tag, "_vld"}, 64'(bus.rf_rdata_vld), 64'(m_vld));
        chk({tag, "_rdata"}, 64'(bus.rf_rdata), 64'(m_rdata));
        chk({tag, "_dir"}, 64'(dir), 64'(m_live[1][0]));
        chk({tag, "_addr"}, 64'(xaddr), 64'({m_live[3][7:0], m_live[2]}));
        chk({tag, "_c"}, 64'(xc), 64'(m_live[4][15:0]));
        chk({tag, "_w"}, 64'(xw), 64'(m_live[5][15:0]));
        chk({tag, "_sw"}, 64'(xsw), 64'(m_live[6]));
    endtask

    // one bus cycle: drive at negedge, model at posedge, compare #1 later
    task automatic step(bit wr, bit rd, logic [7:0] a, logic [31:0] d,
                        bit dn, bit ex, string tag);
        int  idx;
        bit  mapped;
        bit  kick;
        bit  err;
        bus.rf_wr_en = wr;
        bus.rf_rd_en = rd;
        bus.rf_addr  = a;
        bus.rf_wdata = d;
        cdma_done    = dn;
        except_trig  = ex;
        @(posedge clk);
        mapped = (a[1:0] == 2'b00) && (a <= 8'h1C);
        idx    = int'(a >> 2);
        m_vld  = rd;
        if (rd) m_rdata = model_read(a);
        kick = wr && mapped && idx == 0 && d[0] && !m_active;
        err  = wr && mapped && idx == 0 && m_active;
        if (wr && mapped && idx >= 1 && idx <= 6) begin
`ifdef CDMA_RF_SHADOW_EN
            m_desc[idx] = d & fmask(idx);
`else
            if (m_active) err = 1;
            else m_desc[idx] = d & fmask(idx);
`endif
        end
        if (wr && mapped && idx == 7) begin
            if (d[0]) m_exc = 0;
            if (d[2]) m_err = 0;
            if (d[3]) m_done = 0;
        end
        if (ex) m_exc = 1;
        if (dn) m_done = 1;
        if (err) m_err = 1;
        if (m_kick) m_kick = 0;
        else if (m_active && (dn || ex)) m_active = 0;
        if (kick) begin
            m_active = 1;
            m_kick   = 1;
`ifdef CDMA_RF_SHADOW_EN
            m_live = m_desc;
`endif
        end
`ifndef CDMA_RF_SHADOW_EN
        m_live = m_desc;
`endif
        m_sf = kick;
        #1;
        cmp_outputs(tag);
        @(negedge clk);
    endtask

    task automatic idle(string tag);
        step(0, 0, 8'h00, 32'h0, 0, 0, tag);
    endtask

    task automatic wr(logic [7:0] a, logic [31:0] d, string tag);
        step(1, 0, a, d, 0, 0, tag);
    endtask

    task automatic rd(logic [7:0] a, string tag);
        step(0, 1, a, 32'h0, 0, 0, tag);
    endtask

    task automatic apply_reset(string tag);
        rst_n = 1'b0;
        bus.rf_wr_en = 0;
        bus.rf_rd_en = 0;
        cdma_done    = 0;
        except_trig  = 0;
        model_reset();
        #1;
        cmp_outputs(tag);
        repeat (2) begin
            @(posedge clk);
            #1;
            chk({tag, "_sf_in_rst"}, 64'(sfence), 64'h0);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        bus.rf_wr_en = 0;
        bus.rf_rd_en = 0;
        bus.rf_addr  = '0;
        bus.rf_wdata = '0;
        @(negedge clk);
        apply_reset("rst");

        // reset values
        for (int i = 0; i < 8; i++) begin
            rd(8'(i * 4), "t1_rd");
            chk("t1_zero", 64'(bus.rf_rdata), 64'h0);
        end
        idle("t1_idle");

        // program and kick
        wr(8'h08, 32'h1000_0000, "t2_lsb");
        wr(8'h0C, 32'h12, "t2_msb");
        wr(8'h10, 32'd3, "t2_c");
        wr(8'h14, 32'd64, "t2_w");
        wr(8'h18, 32'd256, "t2_sw");
        wr(8'h00, 32'h1, "t2_kick");
        chk("t2_sfence", 64'(sfence), 64'h1);
        chk("t2_xaddr", 64'(xaddr), 64'h12_1000_0000);
        rd(8'h1C, "t2_rdsts");
        chk("t2_busy", 64'(bus.rf_rdata), 64'h2);
        chk("t2_sf_once", 64'(sfence), 64'h0);
        step(0, 0, 8'h00, 32'h0, 1, 0, "t2_done");
        rd(8'h1C, "t2_rdsts2");
        chk("t2_donestk", 64'(bus.rf_rdata), 64'h8);
        chk("t2_irq", 64'(irq), 64'h1);
        wr(8'h1C, 32'hF, "t2_clr");

        // exception and done together
        wr(8'h00, 32'h1, "t3_kick");
        idle("t3_idle");
        step(0, 0, 8'h00, 32'h0, 1, 1, "t3_both");
        rd(8'h1C, "t3_rdsts");
        chk("t3_sts9", 64'(bus.rf_rdata), 64'h9);
        wr(8'h1C, 32'h9, "t3_w1c");
        rd(8'h1C, "t3_rdsts2");
        chk("t3_sts0", 64'(bus.rf_rdata), 64'h0);
        chk("t3_irq0", 64'(irq), 64'h0);

        // busy protection
        wr(8'h00, 32'h1, "t4_kick");
        idle("t4_idle");
        wr(8'h00, 32'h1, "t4_kick2");
        wr(8'h10, 32'h7, "t4_c7");
        rd(8'h10, "t4_rdc");
`ifdef CDMA_RF_SHADOW_EN
        chk("t4_rdc7", 64'(bus.rf_rdata), 64'h7);
`else
        chk("t4_rdc3", 64'(bus.rf_rdata), 64'h3);
`endif
        chk("t4_outc", 64'(xc), 64'h3);
        rd(8'h1C, "t4_rdsts");
        chk("t4_wrerr", 64'(bus.rf_rdata), 64'h6);
        step(0, 0, 8'h00, 32'h0, 1, 0, "t4_done");
        wr(8'h1C, 32'hF, "t4_clr");
        wr(8'h00, 32'h1, "t4_kick3");
`ifdef CDMA_RF_SHADOW_EN
        chk("t4_newc", 64'(xc), 64'h7);
`endif
        idle("t4_idle2");

        // set beats W1C
        step(0, 0, 8'h00, 32'h0, 0, 1, "t5_exc");
        step(1, 0, 8'h1C, 32'h1, 0, 1, "t5_race");
        rd(8'h1C, "t5_rdsts");
        chk("t5_exc_kept", 64'(bus.rf_rdata[0]), 64'h1);
        wr(8'h1C, 32'hF, "t5_clr");

        // reset mid busy
        wr(8'h00, 32'h1, "t6_kick");
        idle("t6_idle");
        apply_reset("t6_rst");
        rd(8'h1C, "t6_rdsts");
        chk("t6_sts0", 64'(bus.rf_rdata), 64'h0);
        repeat (4) idle("t6_post");

        // random traffic
        for (int n = 0; n < 3000; n++) begin
            logic [7:0]  a;
            logic [31:0] d;
            bit          w;
            bit          r;
            w = ($urandom % 3) == 0;
            r = ($urandom % 3) == 0;
            if (($urandom % 8) == 0) a = 8'($urandom);
            else a = 8'(($urandom % 8) * 4);
            d = $urandom;
            step(w, r, a, d, ($urandom % 8) == 0,
                 ($urandom % 12) == 0, "rnd");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
